// File: rtl/seq_match_logger.sv
// Timestamps single-cycle match pulses from the a##1 b##1 c detector and queues them in a small FIFO.
// Define SEQ_MATCH_LOGGER_GAP_EN to also store and present the gap since the previous logged match.
module seq_match_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             match_i,
  input  logic             clr_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [TS_W-1:0]  evt_ts_o,
`ifdef SEQ_MATCH_LOGGER_GAP_EN
  output logic [TS_W-1:0]  evt_gap_o,
`endif
  output logic [CNT_W-1:0] evt_cnt_o,
  output logic [LW-1:0]    level_o,
  output logic             overflow_o
);

  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  ts_mem [DEPTH];
  logic [TS_W-1:0]  last_ts_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign pop   = !empty && evt_ready_i;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push  = match_i && (!full || pop);
  assign drop  = match_i && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      last_ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (clr_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop) begin
          rd_ptr_q  <= rd_ptr_q + PW'(1);
          last_ts_q <= ts_mem[rd_ptr_q];
        end
        if (push && !pop)      level_q <= level_q + LW'(1);
        else if (pop && !push) level_q <= level_q - LW'(1);
        if (match_i && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clr_i && push) ts_mem[wr_ptr_q] <= ts_q;
  end

  // Once drained, the head shows the last popped entry rather than stale storage.
  assign evt_ts_o    = empty ? last_ts_q : ts_mem[rd_ptr_q];
  assign evt_valid_o = !empty;
  assign evt_cnt_o   = cnt_q;
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;

`ifdef SEQ_MATCH_LOGGER_GAP_EN
  logic [TS_W-1:0] gap_mem [DEPTH];
  logic [TS_W-1:0] last_push_ts_q;
  logic [TS_W-1:0] last_gap_q;
  logic            have_push_q;
  logic [TS_W-1:0] gap_new;

  assign gap_new = have_push_q ? (ts_q - last_push_ts_q) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_push_ts_q <= '0;
      last_gap_q     <= '0;
      have_push_q    <= 1'b0;
    end else if (clr_i) begin
      have_push_q <= 1'b0;
    end else begin
      if (push) begin
        last_push_ts_q <= ts_q;
        have_push_q    <= 1'b1;
      end
      if (pop) last_gap_q <= gap_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clr_i && push) gap_mem[wr_ptr_q] <= gap_new;
  end

  assign evt_gap_o = empty ? last_gap_q : gap_mem[rd_ptr_q];
`endif

endmodule

// File: tb/tb_seq_match_logger.sv
// Scoreboard bench for seq_match_logger: default instance plus a TS_W=4/CNT_W=2 instance for wrap and saturation.
// Gap checks are active when SEQ_MATCH_LOGGER_GAP_EN is defined.
module tb_seq_match_logger;

  logic        clk = 1'b0;
  logic        rst_n, match, clr, ready;
  logic        valid, ovf;
  logic [15:0] ts, gap;
  logic [7:0]  cnt;
  logic [2:0]  level;

  logic        match_s, clr_s, ready_s;
  logic        valid_s, ovf_s;
  logic [3:0]  ts_s, gap_s;
  logic [1:0]  cnt_s;
  logic [2:0]  level_s;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_ts[$];
  logic [15:0] exp_gap[$];
  logic [15:0] ts_m, last_m;
  bit          first_m;
  int          cnt_m;
  bit          ovf_m;

  always #5 clk = ~clk;

  seq_match_logger dut (
    .clk(clk), .rst_n(rst_n), .match_i(match), .clr_i(clr),
    .evt_valid_o(valid), .evt_ready_i(ready), .evt_ts_o(ts),
`ifdef SEQ_MATCH_LOGGER_GAP_EN
    .evt_gap_o(gap),
`endif
    .evt_cnt_o(cnt), .level_o(level), .overflow_o(ovf)
  );

  seq_match_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .match_i(match_s), .clr_i(clr_s),
    .evt_valid_o(valid_s), .evt_ready_i(ready_s), .evt_ts_o(ts_s),
`ifdef SEQ_MATCH_LOGGER_GAP_EN
    .evt_gap_o(gap_s),
`endif
    .evt_cnt_o(cnt_s), .level_o(level_s), .overflow_o(ovf_s)
  );

`ifndef SEQ_MATCH_LOGGER_GAP_EN
  assign gap   = '0;
  assign gap_s = '0;
`endif

  // One clock: update the scoreboard from the current inputs, compare popped heads, then advance.
  task automatic step();
    bit pop;
    logic [15:0] g;
    if (!rst_n) begin
      exp_ts.delete(); exp_gap.delete();
      cnt_m = 0; ovf_m = 0; first_m = 1; last_m = '0;
    end else if (clr) begin
      exp_ts.delete(); exp_gap.delete();
      cnt_m = 0; ovf_m = 0; first_m = 1;
    end else begin
      pop = (exp_ts.size() > 0) && ready;
      if (pop) begin
        n_checks++;
        if (ts !== exp_ts[0]) begin
          n_fail++;
          $display("FAIL pop_ts: got %0d expected %0d", ts, exp_ts[0]);
        end
`ifdef SEQ_MATCH_LOGGER_GAP_EN
        n_checks++;
        if (gap !== exp_gap[0]) begin
          n_fail++;
          $display("FAIL pop_gap: got %0d expected %0d", gap, exp_gap[0]);
        end
`endif
        void'(exp_ts.pop_front());
        void'(exp_gap.pop_front());
      end
      if (match) begin
        if (cnt_m < 255) cnt_m++;
        if (exp_ts.size() < 4) begin
          g = first_m ? 16'd0 : 16'(ts_m - last_m);
          exp_ts.push_back(ts_m);
          exp_gap.push_back(g);
          last_m  = ts_m;
          first_m = 0;
        end else begin
          ovf_m = 1;
        end
      end
    end
    ts_m = rst_n ? 16'(ts_m + 16'd1) : 16'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; step(); step(); rst_n = 1;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", level); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", valid); end
    n_checks++; if (ts !== 16'd0)   begin n_fail++; $display("FAIL rst_ts: got %0d expected 0", ts); end
    n_checks++; if (cnt !== 8'd0)   begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", cnt); end
    n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL rst_ovf: got %0b expected 0", ovf); end
  endtask

  task automatic test_basic();
    repeat (5) step();
    match = 1; repeat (3) step(); match = 0;
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL basic_level: got %0d expected 3", level); end
    n_checks++; if (cnt !== 8'd3)   begin n_fail++; $display("FAIL basic_cnt: got %0d expected 3", cnt); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", valid); end
    n_checks++; if (ts !== 16'd5)   begin n_fail++; $display("FAIL basic_head: got %0d expected 5", ts); end
`ifdef SEQ_MATCH_LOGGER_GAP_EN
    n_checks++; if (gap !== 16'd0)  begin n_fail++; $display("FAIL basic_gap: got %0d expected 0", gap); end
`endif
    repeat (2) step();
    n_checks++; if (ts !== 16'd5)   begin n_fail++; $display("FAIL hold_head: got %0d expected 5", ts); end
  endtask

  task automatic test_drain();
    ready = 1; repeat (3) step(); ready = 0;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %0b expected 0", valid); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL drain_level: got %0d expected 0", level); end
    n_checks++; if (ts !== 16'd7)   begin n_fail++; $display("FAIL drain_hold: got %0d expected 7", ts); end
    ready = 1; step(); ready = 0;
    n_checks++; if (level !== 3'd0 || ts !== 16'd7) begin
      n_fail++; $display("FAIL empty_ready: got level %0d ts %0d expected 0 and 7", level, ts);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] t0;
    clr = 1; step(); clr = 0;
    t0 = ts_m;
    match = 1; repeat (6) step(); match = 0;
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d expected 4", level); end
    n_checks++; if (ovf !== 1'b1)   begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", ovf); end
    n_checks++; if (cnt !== 8'd6)   begin n_fail++; $display("FAIL ovf_cnt: got %0d expected 6", cnt); end
    n_checks++; if (ts !== t0)      begin n_fail++; $display("FAIL ovf_head: got %0d expected %0d", ts, t0); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] t0, tnew;
    t0 = exp_ts[1];
    tnew = ts_m;
    match = 1; ready = 1; step(); match = 0; ready = 0;
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fpp_level: got %0d expected 4", level); end
    n_checks++; if (ovf !== 1'b1)   begin n_fail++; $display("FAIL fpp_ovf: got %0b expected 1", ovf); end
    n_checks++; if (ts !== t0)      begin n_fail++; $display("FAIL fpp_head: got %0d expected %0d", ts, t0); end
    ready = 1; repeat (4) step(); ready = 0;
    n_checks++; if (ts !== tnew || level !== 3'd0) begin
      n_fail++; $display("FAIL fpp_tail: got ts %0d level %0d expected %0d and 0", ts, level, tnew);
    end
  endtask

  task automatic test_clear();
    logic [15:0] tc;
    match = 1; repeat (2) step(); match = 0;
    n_checks++; if (level !== 3'd2) begin n_fail++; $display("FAIL clr_pre_level: got %0d expected 2", level); end
    clr = 1; match = 1; ready = 1; step(); clr = 0; match = 0; ready = 0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL clr_level: got %0d expected 0", level); end
    n_checks++; if (cnt !== 8'd0)   begin n_fail++; $display("FAIL clr_cnt: got %0d expected 0", cnt); end
    n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL clr_ovf: got %0b expected 0", ovf); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %0b expected 0", valid); end
    tc = ts_m;
    match = 1; step(); match = 0;
    n_checks++; if (ts !== tc)      begin n_fail++; $display("FAIL clr_ts_cont: got %0d expected %0d", ts, tc); end
    n_checks++; if (cnt !== 8'd1)   begin n_fail++; $display("FAIL clr_recount: got %0d expected 1", cnt); end
`ifdef SEQ_MATCH_LOGGER_GAP_EN
    n_checks++; if (gap !== 16'd0)  begin n_fail++; $display("FAIL clr_gap: got %0d expected 0", gap); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] b;
    b = ts_m;
    ready = 1; match = 1; repeat (4) step(); match = 0; step(); ready = 0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL b2b_level: got %0d expected 0", level); end
    n_checks++; if (cnt !== 8'd5)   begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 5", cnt); end
    n_checks++; if (ts !== 16'(b + 16'd3)) begin n_fail++; $display("FAIL b2b_last: got %0d expected %0d", ts, 16'(b + 16'd3)); end
  endtask

  task automatic test_small();
    rst_n = 0; step(); step(); rst_n = 1;
    repeat (15) step();
    match_s = 1; repeat (2) step(); match_s = 0;
    n_checks++; if (level_s !== 3'd2) begin n_fail++; $display("FAIL wrap_level: got %0d expected 2", level_s); end
    n_checks++; if (ts_s !== 4'd15)   begin n_fail++; $display("FAIL wrap_head: got %0d expected 15", ts_s); end
    n_checks++; if (cnt_s !== 2'd2)   begin n_fail++; $display("FAIL wrap_cnt: got %0d expected 2", cnt_s); end
    ready_s = 1; step(); ready_s = 0;
    n_checks++; if (ts_s !== 4'd0)    begin n_fail++; $display("FAIL wrap_second: got %0d expected 0", ts_s); end
`ifdef SEQ_MATCH_LOGGER_GAP_EN
    n_checks++; if (gap_s !== 4'd1)   begin n_fail++; $display("FAIL wrap_gap: got %0d expected 1", gap_s); end
`endif
    clr_s = 1; step(); clr_s = 0;
    match_s = 1; ready_s = 1; repeat (5) step(); match_s = 0; ready_s = 0;
    n_checks++; if (cnt_s !== 2'd3)   begin n_fail++; $display("FAIL sat_cnt: got %0d expected 3", cnt_s); end
    n_checks++; if (ovf_s !== 1'b0)   begin n_fail++; $display("FAIL sat_ovf: got %0b expected 0", ovf_s); end
    n_checks++; if (level_s !== 3'd1) begin n_fail++; $display("FAIL sat_level: got %0d expected 1", level_s); end
  endtask

  initial begin
    rst_n = 0; match = 0; clr = 0; ready = 0;
    match_s = 0; clr_s = 0; ready_s = 0;
    ts_m = '0; last_m = '0; first_m = 1; cnt_m = 0; ovf_m = 0;
    #1;
    test_reset();
    test_basic();
    test_drain();
    test_overflow();
    test_full_push_pop();
    test_clear();
    test_back_to_back();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
